// File: rtl/pipelined_magnitude_comparator.sv
// rtl/pipelined_magnitude_comparator.sv - pipelined MSB-segment-first magnitude comparator
module pipelined_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NSTAGE = WIDTH / SEG;
    localparam int LAST   = NSTAGE - 1;
    // Inter-stage registers sit between stage k and k+1; the final stage registers only the result.
    localparam int PIPE   = (NSTAGE > 1) ? NSTAGE - 1 : 1;

    generate
        if ((WIDTH % SEG) != 0 || WIDTH < 2) begin : gBadConfig
            $error("pipelined_magnitude_comparator: WIDTH must be a multiple of SEG and at least 2");
        end
    endgenerate

    // A single global stall keeps every stage intact while the result is not taken.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Mode-dependent operand pre-transform feeding stage 0
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             smIn;
    logic             saIn;
    logic             sbIn;
    logic             zzIn;

    // Pipeline state between stages
    logic             validQ [PIPE];
    logic [WIDTH-1:0] aQ     [PIPE];
    logic [WIDTH-1:0] bQ     [PIPE];
    logic             decQ   [PIPE];
    logic             gQ     [PIPE];
    logic             lQ     [PIPE];
    logic             smQ    [PIPE];
    logic             saQ    [PIPE];
    logic             sbQ    [PIPE];
    logic             zzQ    [PIPE];

    // Per-stage view of what enters the stage this cycle, and its decision after this segment
    logic             srcValid [NSTAGE];
    logic [WIDTH-1:0] srcA     [NSTAGE];
    logic [WIDTH-1:0] srcB     [NSTAGE];
    logic             srcDec   [NSTAGE];
    logic             srcG     [NSTAGE];
    logic             srcL     [NSTAGE];
    logic             srcSm    [NSTAGE];
    logic             srcSa    [NSTAGE];
    logic             srcSb    [NSTAGE];
    logic             srcZz    [NSTAGE];
    logic             nxtDec   [NSTAGE];
    logic             nxtG     [NSTAGE];
    logic             nxtL     [NSTAGE];

    // Final result after sign-magnitude correction
    logic finGt;
    logic finEq;
    logic finLt;

    // Output registers
    logic outValidQ;
    logic gtQ;
    logic eqQ;
    logic ltQ;

    // Two's complement flips both MSBs so unsigned order matches signed order;
    // sign-magnitude strips the sign bits and keeps them aside for the final fix-up.
    always_comb begin
        aIn  = a;
        bIn  = b;
        smIn = 1'b0;
        saIn = a[WIDTH-1];
        sbIn = b[WIDTH-1];
        zzIn = (a[WIDTH-2:0] == '0) && (b[WIDTH-2:0] == '0);
        case (mode)
            2'b01: begin
                aIn[WIDTH-1] = ~a[WIDTH-1];
                bIn[WIDTH-1] = ~b[WIDTH-1];
            end
            2'b10: begin
                smIn         = 1'b1;
                aIn[WIDTH-1] = 1'b0;
                bIn[WIDTH-1] = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Select each stage's source (inputs for stage 0, previous register otherwise)
    always_comb begin
        srcValid[0] = in_valid;
        srcA[0]     = aIn;
        srcB[0]     = bIn;
        srcDec[0]   = 1'b0;
        srcG[0]     = 1'b0;
        srcL[0]     = 1'b0;
        srcSm[0]    = smIn;
        srcSa[0]    = saIn;
        srcSb[0]    = sbIn;
        srcZz[0]    = zzIn;
        for (int k = 1; k < NSTAGE; k++) begin
            srcValid[k] = validQ[k-1];
            srcA[k]     = aQ[k-1];
            srcB[k]     = bQ[k-1];
            srcDec[k]   = decQ[k-1];
            srcG[k]     = gQ[k-1];
            srcL[k]     = lQ[k-1];
            srcSm[k]    = smQ[k-1];
            srcSa[k]    = saQ[k-1];
            srcSb[k]    = sbQ[k-1];
            srcZz[k]    = zzQ[k-1];
        end
    end

    // Stage k resolves segment NSTAGE-1-k unless an earlier segment already decided
    always_comb begin
        logic [SEG-1:0] segA;
        logic [SEG-1:0] segB;
        segA = '0;
        segB = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            segA      = srcA[k][(NSTAGE-1-k)*SEG +: SEG];
            segB      = srcB[k][(NSTAGE-1-k)*SEG +: SEG];
            nxtDec[k] = srcDec[k];
            nxtG[k]   = srcG[k];
            nxtL[k]   = srcL[k];
            if (!srcDec[k]) begin
                if (segA > segB) begin
                    nxtDec[k] = 1'b1;
                    nxtG[k]   = 1'b1;
                end else if (segA < segB) begin
                    nxtDec[k] = 1'b1;
                    nxtL[k]   = 1'b1;
                end
            end
        end
    end

    // Sign-magnitude fix-up: zeros compare equal, differing signs decide, two negatives invert
    always_comb begin
        finGt = nxtG[LAST];
        finLt = nxtL[LAST];
        finEq = !nxtDec[LAST];
        if (srcSm[LAST]) begin
            if (srcZz[LAST]) begin
                finGt = 1'b0;
                finEq = 1'b1;
                finLt = 1'b0;
            end else if (srcSa[LAST] != srcSb[LAST]) begin
                finGt = !srcSa[LAST];
                finLt = srcSa[LAST];
                finEq = 1'b0;
            end else if (srcSa[LAST]) begin
                finGt = nxtL[LAST];
                finLt = nxtG[LAST];
            end
        end
    end

    // Advance all inter-stage registers together unless the output is stalled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < PIPE; k++) begin
                validQ[k] <= 1'b0;
                aQ[k]     <= '0;
                bQ[k]     <= '0;
                decQ[k]   <= 1'b0;
                gQ[k]     <= 1'b0;
                lQ[k]     <= 1'b0;
                smQ[k]    <= 1'b0;
                saQ[k]    <= 1'b0;
                sbQ[k]    <= 1'b0;
                zzQ[k]    <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NSTAGE - 1; k++) begin
                validQ[k] <= srcValid[k];
                aQ[k]     <= srcA[k];
                bQ[k]     <= srcB[k];
                decQ[k]   <= nxtDec[k];
                gQ[k]     <= nxtG[k];
                lQ[k]     <= nxtL[k];
                smQ[k]    <= srcSm[k];
                saQ[k]    <= srcSa[k];
                sbQ[k]    <= srcSb[k];
                zzQ[k]    <= srcZz[k];
            end
        end
    end

    // Final stage registers the corrected result; flags are forced low for empty slots
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            outValidQ <= 1'b0;
            gtQ       <= 1'b0;
            eqQ       <= 1'b0;
            ltQ       <= 1'b0;
        end else if (!stall) begin
            outValidQ <= srcValid[LAST];
            gtQ       <= srcValid[LAST] && finGt;
            eqQ       <= srcValid[LAST] && finEq;
            ltQ       <= srcValid[LAST] && finLt;
        end
    end

    assign out_valid = outValidQ;
    assign gt        = gtQ;
    assign eq        = eqQ;
    assign lt        = ltQ;

endmodule
